softmax_normalizer: RTL and testbench

Downstream consumer of `exp_fixed_point`: collects a vector of N exponentials, accumulates their sum, and emits each element divided by the sum as an unsigned Q0.WIDTH probability. It is the normalisation stage of the fixed-point softmax path. It uses a valid/ready stream on both sides, an N-entry buffer, and one multi-cycle restoring divider shared across elements.

---
 rtl/softmax_normalizer.sv | 131 +++++++++++++
 tb/tb_softmax_normalizer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/softmax_normalizer.sv
// Softmax normalisation stage: buffers N exponentials, sums them, then divides
// each by the sum with one shared restoring divider to emit Q0.WIDTH probabilities.
module softmax_normalizer #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready
);

  localparam int DW    = 2 * WIDTH;
  localparam int SUM_W = DW + $clog2(N);
  localparam int REM_W = SUM_W + 1;
  localparam int QW    = WIDTH + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {COLLECT, DIVIDE, OUTPUT} state_t;

  state_t            state, state_next;
  logic [DW-1:0]     elem_buf [N];
  logic [SUM_W-1:0]  sum;
  logic [IDX_W-1:0]  idx, elem;
  logic [CNT_W-1:0]  cnt;
  logic [REM_W-1:0]  rem;
  logic [QW-1:0]     q;

  logic [DW-1:0]     clamped;
  logic              accept, last_in, last_elem, div_last, ge;
  logic [REM_W-1:0]  trial, rem_next;
  logic [QW-1:0]     q_next;
  logic [WIDTH-1:0]  result;

  always_comb begin
    clamped   = in_data[DW-1] ? '0 : in_data;
    accept    = (state == COLLECT) && in_valid && in_ready;
    last_in   = (idx == IDX_W'(N - 1));
    last_elem = (elem == IDX_W'(N - 1));
    div_last  = (cnt == CNT_W'(WIDTH));
    // Iteration 0 compares the unshifted element; later iterations shift first.
    trial     = (cnt == '0) ? REM_W'(elem_buf[elem]) : (rem << 1);
    ge        = (trial >= {1'b0, sum});
    rem_next  = ge ? (trial - {1'b0, sum}) : trial;
    q_next    = (q << 1) | QW'(ge);
    if (sum == '0)
      result = '0;
    else if (q_next[WIDTH])
      result = '1;
    else
      result = q_next[WIDTH-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (accept && last_in) state_next = DIVIDE;
      DIVIDE:  if (div_last) state_next = OUTPUT;
      OUTPUT:  if (out_ready) state_next = last_elem ? COLLECT : DIVIDE;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= COLLECT;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      sum       <= '0;
      idx       <= '0;
      elem      <= '0;
      cnt       <= '0;
      rem       <= '0;
      q         <= '0;
      for (int unsigned i = 0; i < N; i++) elem_buf[i] <= '0;
    end else begin
      in_ready  <= (state_next == COLLECT);
      out_valid <= (state_next == OUTPUT);
      case (state)
        COLLECT: begin
          if (accept) begin
            elem_buf[idx] <= clamped;
            sum           <= sum + SUM_W'(clamped);
            idx           <= idx + IDX_W'(1);
            if (last_in) begin
              elem <= '0;
              cnt  <= '0;
            end
          end
        end
        DIVIDE: begin
          rem <= rem_next;
          q   <= q_next;
          cnt <= cnt + CNT_W'(1);
          if (div_last) begin
            out_data <= result;
            out_last <= last_elem;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            cnt <= '0;
            if (last_elem) begin
              sum  <= '0;
              idx  <= '0;
              elem <= '0;
            end else begin
              elem <= elem + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_normalizer.sv
// Self-checking bench for softmax_normalizer: fixed vectors, randomized vectors
// against a plain-arithmetic model, backpressure and mid-operation reset.
module tb_softmax_normalizer;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int LAT   = WIDTH + 1;
  localparam int BOUND = 60;

  typedef int vec_t [N];
  typedef struct {
    vec_t v;
    vec_t e;
  } rec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic [2*WIDTH-1:0] in_data = '0;
  logic               in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic               out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  softmax_normalizer #(.WIDTH(WIDTH), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: clamp negatives, sum, floor(v*2^W/sum), saturate, zero sum -> 0.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    longint s = 0;
    longint c, qq;
    for (int i = 0; i < N; i++) s += (v[i] < 0) ? 0 : v[i];
    for (int i = 0; i < N; i++) begin
      c = (v[i] < 0) ? 0 : v[i];
      if (s == 0) qq = 0;
      else qq = (c * (longint'(1) << WIDTH)) / s;
      if (qq > (1 << WIDTH) - 1) qq = (1 << WIDTH) - 1;
      r[i] = int'(qq);
    end
    return r;
  endfunction

  task automatic send_vector(input vec_t v, input bit hold_valid);
    int cyc;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = (2*WIDTH)'(v[i]);
      cyc = 0;
      while (!in_ready && cyc < BOUND) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (cyc >= BOUND) chk("in_ready_timeout", cyc, 0);
      @(posedge clk); #1;
    end
    if (hold_valid) in_data = 16'h7fff;
    else in_valid = 1'b0;
  endtask

  task automatic receive_vector(input vec_t e, input int n_out, input int bp_elem, input int bp_cyc);
    int cyc;
    int d0, l0;
    for (int i = 0; i < n_out; i++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!out_valid && cyc < BOUND);
      chk("latency", cyc, LAT);
      chk("out_data", int'(out_data), e[i]);
      chk("out_last", int'(out_last), (i == N - 1) ? 1 : 0);
      chk("in_ready_in_output", int'(in_ready), 0);
      if (i == bp_elem) begin
        d0 = int'(out_data);
        l0 = int'(out_last);
        for (int b = 0; b < bp_cyc; b++) begin
          @(posedge clk); #1;
          chk("bp_valid", int'(out_valid), 1);
          chk("bp_data", int'(out_data), d0);
          chk("bp_last", int'(out_last), l0);
          chk("bp_in_ready", int'(in_ready), 0);
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("valid_drop", int'(out_valid), 0);
      if (i == N - 1) begin
        chk("in_ready_after_last", int'(in_ready), 1);
        in_valid = 1'b0;
      end
    end
  endtask

  rec_t tbl [6];
  vec_t v, e;

  initial begin
    tbl[0].v = '{341, 341, 341, 341}; tbl[0].e = '{64, 64, 64, 64};
    tbl[1].v = '{1, 2, 3, 4};         tbl[1].e = '{25, 51, 76, 102};
    tbl[2].v = '{100, 0, 0, 0};       tbl[2].e = '{255, 0, 0, 0};
    tbl[3].v = '{-5, 20, 0, 0};       tbl[3].e = '{0, 255, 0, 0};
    tbl[4].v = '{0, 0, 0, 0};         tbl[4].e = '{0, 0, 0, 0};
    tbl[5].v = '{32767, 32767, -32768, 1}; tbl[5].e = '{127, 127, 0, 0};

    #12;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_rise", int'(in_ready), 1);

    for (int t = 0; t < 6; t++) begin
      send_vector(tbl[t].v, 1'b0);
      receive_vector(tbl[t].e, N, -1, 0);
    end

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: v[i] = -int'($urandom_range(1, 32768));
          1: v[i] = int'($urandom_range(0, 15));
          default: v[i] = int'($urandom_range(0, 32767));
        endcase
      end
      e = model(v);
      send_vector(v, 1'b0);
      receive_vector(e, N, int'($urandom_range(0, N)), int'($urandom_range(1, 3)));
    end

    // Backpressure on element 1 with in_valid held high through DIVIDE/OUTPUT.
    v = '{1, 2, 3, 4};
    send_vector(v, 1'b1);
    receive_vector(model(v), N, 1, 3);
    v = '{10, 10, 10, 10};
    send_vector(v, 1'b0);
    receive_vector('{64, 64, 64, 64}, N, -1, 0);

    // Reset during the divide of element 2.
    v = '{341, 341, 341, 341};
    send_vector(v, 1'b0);
    receive_vector(model(v), 2, -1, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    chk("mid_rst_out_last", int'(out_last), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("held_rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);
    v = '{1, 2, 3, 4};
    send_vector(v, 1'b0);
    receive_vector('{25, 51, 76, 102}, N, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
